data_mem_responder: RTL and testbench



---
 rtl/data_mem_pkg.sv | 13 +
 rtl/data_mem_array.sv | 24 ++
 rtl/data_mem_responder.sv | 137 +++++++++++++
 tb/tb_data_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package data_mem_pkg;

    localparam int WAIT_CNT_W = 4;
    localparam int ADDR_LSB   = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/data_mem_array.sv
// Word storage: synchronous write, registered read, no reset so it maps onto RAM.
module data_mem_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
        if (re)
            rdata <= mem[idx];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request in flight, WAIT_STATES wait cycles, one-cycle response.
// Define DATA_MEM_ADDR_CHECK_EN to flag misaligned / out-of-range accesses via addr_err.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              resp_valid,
    output logic              busy,
    output logic              addr_err
);

    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit ZERO_WAIT = (WAIT_STATES == 0);

    state_t                 state;
    logic [WAIT_CNT_W-1:0]  wait_cnt;
    logic                   wr_q;
    logic [31:0]            addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic                   rd_hold;
    logic [DATA_W-1:0]      rd_data;

    logic                   acc_fire;
    logic                   acc_write;
    logic                   acc_bad;
    logic [31:0]            acc_addr;
    logic [DATA_W-1:0]      acc_wdata;
    logic [IDX_W-1:0]       acc_idx;

    // With zero wait states the access happens on the acceptance edge, so it
    // works straight off the request inputs instead of the captured copy.
    always_comb begin
        acc_fire  = 1'b0;
        acc_write = wr_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (ZERO_WAIT) begin
            acc_fire  = (state == IDLE) && req_valid;
            acc_write = req_write;
            acc_addr  = mem_addr;
            acc_wdata = mem_data_out;
        end else begin
            acc_fire  = (state == WAIT) && (wait_cnt == '0);
        end
    end

    assign acc_idx = acc_addr[IDX_W+ADDR_LSB-1:ADDR_LSB];

`ifdef DATA_MEM_ADDR_CHECK_EN
    assign acc_bad = (acc_addr[ADDR_LSB-1:0] != '0) ||
                     (acc_addr[31:IDX_W+ADDR_LSB] != '0);
`else
    // Without checking the address simply wraps; these bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{acc_addr[31:IDX_W+ADDR_LSB], acc_addr[ADDR_LSB-1:0]};
    assign acc_bad = 1'b0;
`endif

    data_mem_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clock_in),
        .we    (acc_fire && acc_write && !acc_bad),
        .re    (acc_fire && !acc_write && !acc_bad),
        .idx   (acc_idx),
        .wdata (acc_wdata),
        .rdata (rd_data)
    );

    // The RAM read register cannot be reset, so a resettable flag selects
    // between it and zero; both only change on access edges.
    assign mem_data_in = rd_hold ? rd_data : '0;

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_hold    <= 1'b0;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q    <= req_write;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_data_out;
                        busy    <= 1'b1;
                        if (ZERO_WAIT) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    addr_err   <= 1'b0;
                    busy       <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (acc_fire) begin
                rd_hold  <= !acc_write && !acc_bad;
                addr_err <= acc_bad;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: two responders (2 and 0 wait states) against an associative-array memory model.
module tb_data_mem_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 256;
    localparam int WS_A  = 2;
    localparam int WS_B  = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic          a_req = 0, a_wr = 0, b_req = 0, b_wr = 0;
    logic [31:0]   a_addr = 0, b_addr = 0;
    logic [DW-1:0] a_wdata = 0, b_wdata = 0;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          a_resp, a_busy, a_err, b_resp, b_busy, b_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl_a [int];
    logic [31:0] mdl_b [int];
    int          keys_a[$];
    int          keys_b[$];

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) dut_a (
        .clock_in(clk), .reset(rst), .req_valid(a_req), .req_write(a_wr),
        .mem_addr(a_addr), .mem_data_out(a_wdata), .mem_data_in(a_rdata),
        .resp_valid(a_resp), .busy(a_busy), .addr_err(a_err)
    );

    data_mem_responder #(.DATA_W(DW), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) dut_b (
        .clock_in(clk), .reset(rst), .req_valid(b_req), .req_write(b_wr),
        .mem_addr(b_addr), .mem_data_out(b_wdata), .mem_data_in(b_rdata),
        .resp_valid(b_resp), .busy(b_busy), .addr_err(b_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int key(input logic [31:0] addr);
        return int'((addr >> 2) % DEPTH);
    endfunction

    function automatic bit bad(input logic [31:0] addr);
`ifdef DATA_MEM_ADDR_CHECK_EN
        return (addr[1:0] != 2'b00) || ((addr >> 2) >= DEPTH);
`else
        return (addr == 32'hFFFF_FFFF) && (addr != 32'hFFFF_FFFF);
`endif
    endfunction

    function automatic logic [31:0] mk_addr(input int k);
`ifdef DATA_MEM_ADDR_CHECK_EN
        return 32'(k) << 2;
`else
        // Random upper and low bits must be ignored by the wrapping decode.
        return ($urandom & ~32'(DEPTH * 4 - 1)) | (32'(k) << 2) | 32'($urandom_range(0, 3));
`endif
    endfunction

    function automatic logic get_resp(input int s);
        return (s != 0) ? b_resp : a_resp;
    endfunction

    function automatic logic [31:0] get_rdata(input int s);
        return (s != 0) ? b_rdata : a_rdata;
    endfunction

    function automatic logic get_busy(input int s);
        return (s != 0) ? b_busy : a_busy;
    endfunction

    task automatic drive(input int s, input logic v, input logic w, input logic [31:0] ad,
                         input logic [31:0] d);
        if (s != 0) begin b_req = v; b_wr = w; b_addr = ad; b_wdata = d; end
        else        begin a_req = v; a_wr = w; a_addr = ad; a_wdata = d; end
    endtask

    // One request: present at negedge, drop after acceptance, wait for the response.
    task automatic req(input int s, input logic w, input logic [31:0] ad, input logic [31:0] d,
                       output logic [31:0] rd, output logic err, output int lat);
        @(negedge clk);
        drive(s, 1'b1, w, ad, d);
        @(posedge clk); #1;
        drive(s, 1'b0, w, ad, d);
        lat = 0;
        while (!get_resp(s) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd  = get_rdata(s);
        err = (s != 0) ? b_err : a_err;
        @(posedge clk); #1;
        chk("resp_one_cycle", 64'(get_resp(s)), 64'd0);
    endtask

    task automatic op(input int s, input logic w, input logic [31:0] ad, input logic [31:0] d);
        logic [31:0] rd, exp;
        logic        err;
        int          lat, k;
        bit          b;
        k = key(ad);
        b = bad(ad);
        req(s, w, ad, d, rd, err, lat);
        if (w || b) exp = 32'd0;
        else        exp = (s != 0) ? mdl_b[k] : mdl_a[k];
        chk(w ? "latency_wr" : "latency_rd", 64'(lat), 64'((s != 0) ? WS_B : WS_A));
        chk(w ? "rdata_after_wr" : "rdata_rd", 64'(rd), 64'(exp));
        chk("addr_err", 64'(err), 64'(b));
        if (w && !b) begin
            if (s != 0) begin mdl_b[k] = d; keys_b.push_back(k); end
            else        begin mdl_a[k] = d; keys_a.push_back(k); end
        end
    endtask

    // Hold req_valid high for n cycles alternating two pre-written addresses.
    task automatic hold_test(input int s, input int n, input int period,
                             input logic [31:0] a0, input logic [31:0] a1);
        logic [31:0] cur, exp;
        int nresp, nbusy, last;
        cur = a0; nresp = 0; nbusy = 0; last = -1;
        @(negedge clk);
        drive(s, 1'b1, 1'b0, cur, 32'd0);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (get_busy(s)) nbusy++;
            if (get_resp(s)) begin
                nresp++;
                exp = (s != 0) ? mdl_b[key(cur)] : mdl_a[key(cur)];
                chk("hold_rdata", 64'(get_rdata(s)), 64'(exp));
                if (last >= 0) chk("hold_gap", 64'(c - last), 64'(period));
                last = c;
                cur  = (cur == a0) ? a1 : a0;
                drive(s, 1'b1, 1'b0, cur, 32'd0);
            end
        end
        drive(s, 1'b0, 1'b0, cur, 32'd0);
        chk("hold_nresp", 64'(nresp), 64'(n / period));
        chk("hold_nbusy", 64'(nbusy), 64'(n - n / period));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] ad, d;
        int          s, k, cnt;
        logic        w;

        #1;
        chk("rst_rdata", 64'(a_rdata), 64'd0);
        chk("rst_resp",  64'(a_resp),  64'd0);
        chk("rst_busy",  64'(a_busy),  64'd0);
        chk("rst_err",   64'(a_err),   64'd0);
        #11 rst = 1'b0;

        // Round trip on the 2-wait-state instance
        op(0, 1'b1, 32'h10, 32'hABCDEF01);
        op(0, 1'b0, 32'h10, 32'h0);
        op(0, 1'b1, 32'h0,  32'h0BAD_F00D);
        op(0, 1'b1, 32'h4,  32'h5555_AAAA);
        op(0, 1'b1, 32'h20, 32'h1111_2222);
        op(1, 1'b1, 32'h0,  32'hCAFE_0000);
        op(1, 1'b1, 32'h4,  32'hCAFE_0004);
        op(1, 1'b0, 32'h4,  32'h0);

        hold_test(0, 16, WS_A + 2, 32'h0, 32'h4);
        hold_test(1, 8,  WS_B + 2, 32'h0, 32'h4);

`ifdef DATA_MEM_ADDR_CHECK_EN
        op(0, 1'b1, 32'h402, 32'hDEAD_0402);
        op(0, 1'b1, 32'h400, 32'hDEAD_0400);
        op(0, 1'b0, 32'h000, 32'h0);
        op(1, 1'b0, 32'h403, 32'h0);
`endif

        for (int i = 0; i < 48; i++) begin
            s = i % 2;
            w = 1'($urandom);
            if ((s != 0 && keys_b.size() == 0) || (s == 0 && keys_a.size() == 0)) w = 1'b1;
            d = $urandom;
            if (w) begin
                ad = mk_addr(int'($urandom_range(0, DEPTH - 1)));
`ifdef DATA_MEM_ADDR_CHECK_EN
                if ($urandom_range(0, 3) == 0) ad = $urandom;
`endif
            end else begin
                k  = (s != 0) ? keys_b[$urandom_range(0, keys_b.size() - 1)]
                              : keys_a[$urandom_range(0, keys_a.size() - 1)];
                ad = mk_addr(k);
            end
            op(s, w, ad, d);
        end

        // Leave a nonzero read value on mem_data_in, then abort a write mid-WAIT.
        op(0, 1'b0, 32'h4, 32'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("busy_in_wait", 64'(a_busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rdata", 64'(a_rdata), 64'd0);
        chk("async_rst_resp",  64'(a_resp),  64'd0);
        chk("async_rst_busy",  64'(a_busy),  64'd0);
        chk("async_rst_err",   64'(a_err),   64'd0);
        #2 rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (a_resp) cnt++;
        end
        chk("aborted_no_resp", 64'(cnt), 64'd0);
        op(0, 1'b0, 32'h20, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
